// File: rtl/xphm_rd_ctrl.sv
// xphm_rd_ctrl: sweeps XPHM head address ranges with credit-limited reads into an output FIFO stream
module xphm_rd_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_pulse,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           n_heads,
  input  logic [15:0]           n_rep,
  output logic                  busy,
  output logic                  done_pulse,
  output logic                  xphm_rd_en,
  output logic                  xphm_rd_last,
  output logic [ADDR_WIDTH-1:0] xphm_rd_addr,
  input  logic [DATA_WIDTH-1:0] xphm_dout,
  input  logic                  xphm_dout_vld,
  input  logic                  xphm_dout_last,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast_rep,
  output logic                  m_tlast
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = $clog2(RD_LATENCY + 1);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_base, r_addr, w_base;
  logic [15:0] r_nh, r_nr, r_hidx, r_ridx, r_ret, w_nh, w_nr, w_hidx, w_ridx;
  logic r_rd_en, r_last, r_done;
  logic [CW-1:0] r_inflight, r_count;
  logic [CW:0] w_used;
  logic [PW-1:0] r_wr, r_rd;
  logic [FW-1:0] r_flush;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic w_idle, w_start, w_degen, w_hlast, w_final, w_issue, w_push, w_pop, w_valid;
  assign w_idle  = r_state == IDLE;
  assign w_start = w_idle && start_pulse && r_flush == '0;
  assign w_degen = n_heads == 16'd0 || n_rep == 16'd0;
  // In IDLE the first read is issued straight from the command inputs so it appears one cycle after start
  assign w_base  = w_idle ? base_addr : r_base;
  assign w_nh    = w_idle ? n_heads : r_nh;
  assign w_nr    = w_idle ? n_rep : r_nr;
  assign w_hidx  = w_idle ? 16'd0 : r_hidx;
  assign w_ridx  = w_idle ? 16'd0 : r_ridx;
  assign w_hlast = w_hidx == w_nh - 16'd1;
  assign w_final = w_hlast && w_ridx == w_nr - 16'd1;
  assign w_used  = {1'b0, r_inflight} + {1'b0, r_count} + {{CW{1'b0}}, r_rd_en};
  assign w_issue = (w_start ? !w_degen : r_state == ISSUE) && w_used < DEPTH_W;
  assign w_push  = xphm_dout_vld && r_flush == '0;
  assign w_valid = r_count != '0;
  assign w_pop   = w_valid && m_tready;
  assign busy         = !w_idle;
  assign done_pulse   = r_done;
  assign xphm_rd_en   = r_rd_en;
  assign xphm_rd_last = r_last;
  assign xphm_rd_addr = r_addr;
  assign m_tvalid     = w_valid;
  assign {m_tdata, m_tlast_rep, m_tlast} = w_valid ? r_mem[r_rd] : '0;
  always_comb begin
    w_next = r_state;
    if (w_start && !w_degen)
      w_next = w_final ? DRAIN : ISSUE;
    else if (r_state == ISSUE && w_issue && w_final)
      w_next = DRAIN;
    else if (r_state == DRAIN && w_pop && m_tlast)
      w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rd_en    <= 1'b0;
      r_last     <= 1'b0;
      r_addr     <= '0;
      r_done     <= 1'b0;
      r_inflight <= '0;
      r_count    <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_hidx     <= '0;
      r_ridx     <= '0;
      r_ret      <= '0;
      r_flush    <= FW'(RD_LATENCY);
    end else begin
      r_state    <= w_next;
      r_rd_en    <= w_issue;
      r_last     <= w_issue && w_hlast;
      r_done     <= (w_start && w_degen) || (r_state == DRAIN && w_pop && m_tlast);
      r_flush    <= r_flush - FW'(r_flush != '0);
      r_inflight <= r_inflight + CW'(r_rd_en) - CW'(w_push);
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_start) r_ret <= '0;
      else if (w_push && xphm_dout_last) r_ret <= r_ret + 16'd1;
      if (w_issue) begin
        r_addr <= w_base + w_hidx[ADDR_WIDTH-1:0];
        r_hidx <= w_hlast ? 16'd0 : w_hidx + 16'd1;
        r_ridx <= w_ridx + 16'(w_hlast);
      end
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_base <= base_addr;
      r_nh   <= n_heads;
      r_nr   <= n_rep;
    end
    if (w_push) r_mem[r_wr] <= {xphm_dout, xphm_dout_last, xphm_dout_last && r_ret == r_nr - 16'd1};
  end
  always_ff @(posedge clk)
    if (!rst) a_no_overflow: assert (!(w_push && !w_pop && r_count == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_xphm_rd_ctrl.sv
// tb_xphm_rd_ctrl: random-stimulus bench with an XPHM pipeline model and a queue-based stream scoreboard
module tb_xphm_rd_ctrl;
  localparam int LAT = 3;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 1, start_pulse = 0, m_tready = 1;
  logic [9:0] base_addr = '0, xphm_rd_addr;
  logic [15:0] n_heads = '0, n_rep = '0;
  logic busy, done_pulse, xphm_rd_en, xphm_rd_last, m_tvalid, m_tlast_rep, m_tlast;
  logic [63:0] xphm_dout = '0, m_tdata;
  logic xphm_dout_vld = 0, xphm_dout_last = 0;
  xphm_rd_ctrl dut (
    .clk(clk), .rst(rst), .start_pulse(start_pulse), .base_addr(base_addr), .n_heads(n_heads),
    .n_rep(n_rep), .busy(busy), .done_pulse(done_pulse), .xphm_rd_en(xphm_rd_en),
    .xphm_rd_last(xphm_rd_last), .xphm_rd_addr(xphm_rd_addr), .xphm_dout(xphm_dout),
    .xphm_dout_vld(xphm_dout_vld), .xphm_dout_last(xphm_dout_last), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast_rep(m_tlast_rep), .m_tlast(m_tlast)
  );
  always #5 clk = ~clk;
  typedef struct {logic [9:0] a; logic l;} rd_t;
  typedef struct {logic [63:0] d; logic lr; logic l;} hd_t;
  logic [63:0] xmem [1024];
  rd_t exp_rd [$];
  hd_t exp_hd [$];
  logic [9:0] seen_addr [$];
  int nv = 0, nf = 0, cyc = 0, rdy_pct = 100;
  int issued = 0, popped = 0, rd_seen = 0, heads = 0, fl = LAT;
  int cyc_start = 0, first_rd = -1, first_v = -1, done_cyc = -1;
  logic mbusy = 0, exp_done = 0, got_done = 0, chk_rst = 0, stall_prev = 0;
  logic [65:0] prev = '0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nv++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // XPHM model: fixed-latency pipeline returning xmem contents and the sweep-last tag
  initial begin
    logic pv [LAT+1];
    logic pl [LAT+1];
    logic [9:0] pa [LAT+1];
    for (int k = 0; k <= LAT; k++) begin pv[k] = 0; pl[k] = 0; pa[k] = '0; end
    forever begin
      @(posedge clk); #1;
      for (int k = LAT; k > 0; k--) begin pv[k] = pv[k-1]; pl[k] = pl[k-1]; pa[k] = pa[k-1]; end
      pv[0] = xphm_rd_en; pl[0] = xphm_rd_last; pa[0] = xphm_rd_addr;
      xphm_dout_vld = pv[LAT];
      xphm_dout_last = pv[LAT] && pl[LAT];
      xphm_dout = pv[LAT] ? xmem[pa[LAT]] : {$urandom, $urandom};
      m_tready = $urandom_range(0, 99) < rdy_pct;
    end
  end
  // Scoreboard: everything seen at the negedge belongs to one clock cycle
  always @(negedge clk) begin
    logic b0;
    rd_t r;
    hd_t h;
    cyc++;
    if (rst) begin
      exp_rd.delete(); exp_hd.delete();
      mbusy = 0; exp_done = 0; fl = LAT; issued = 0; popped = 0; chk_rst = 1; stall_prev = 0;
    end else begin
      if (chk_rst) begin
        chk("reset_values", 64'({busy, done_pulse, xphm_rd_en, xphm_rd_last, m_tvalid, m_tlast_rep, m_tlast, xphm_rd_addr}), 64'd0);
        chk_rst = 0;
      end
      b0 = mbusy;
      chk("busy", 64'(busy), 64'(mbusy));
      chk("done_pulse", 64'(done_pulse), 64'(exp_done));
      if (done_pulse) begin got_done = 1; done_cyc = cyc; end
      exp_done = 0;
      if (xphm_rd_en) begin
        issued++; rd_seen++; seen_addr.push_back(xphm_rd_addr);
        if (first_rd < 0) first_rd = cyc;
        if (exp_rd.size() == 0) chk("unexpected_read", 64'd1, 64'd0);
        else begin
          r = exp_rd.pop_front();
          chk("rd_addr", 64'(xphm_rd_addr), 64'(r.a));
          chk("rd_last", 64'(xphm_rd_last), 64'(r.l));
        end
      end
      chk("credit_bound", 64'(issued - popped <= DEPTH), 64'd1);
      if (stall_prev) chk("stall_stable", {63'd0, m_tvalid} ^ 64'(prev != {m_tdata, m_tlast_rep, m_tlast}), 64'd1);
      if (m_tvalid && first_v < 0) first_v = cyc;
      if (m_tvalid && m_tready) begin
        popped++; heads++;
        if (exp_hd.size() == 0) chk("unexpected_head", 64'd1, 64'd0);
        else begin
          h = exp_hd.pop_front();
          chk("m_tdata", m_tdata, h.d);
          chk("m_tlast_rep", 64'(m_tlast_rep), 64'(h.lr));
          chk("m_tlast", 64'(m_tlast), 64'(h.l));
          if (h.l) begin exp_done = 1; mbusy = 0; end
        end
      end
      stall_prev = m_tvalid && !m_tready;
      prev = {m_tdata, m_tlast_rep, m_tlast};
      if (start_pulse && !b0 && fl == 0) begin
        cyc_start = cyc; rd_seen = 0; heads = 0; first_rd = -1; first_v = -1; done_cyc = -1;
        seen_addr.delete();
        if (n_heads == 0 || n_rep == 0) exp_done = 1;
        else begin
          mbusy = 1;
          for (int s = 0; s < int'(n_rep); s++)
            for (int k = 0; k < int'(n_heads); k++) begin
              r.a = 10'((int'(base_addr) + k) % 1024);
              r.l = k == int'(n_heads) - 1;
              exp_rd.push_back(r);
              h.d = xmem[r.a]; h.lr = r.l; h.l = r.l && s == int'(n_rep) - 1;
              exp_hd.push_back(h);
            end
        end
      end
      if (fl > 0) fl--;
    end
  end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic cmd(input logic [9:0] b, input int nh, input int nr);
    got_done = 0;
    base_addr = b; n_heads = 16'(nh); n_rep = 16'(nr); start_pulse = 1;
    step();
    start_pulse = 0;
  endtask
  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !got_done; i++) step();
    chk("done_within_budget", 64'(got_done), 64'd1);
    step();
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) xmem[i] = {$urandom, $urandom};
    repeat (3) step();
    rst = 0;
    repeat (6) step();
    cmd(10'h010, 4, 1);
    wait_done(100);
    chk("t1_first_rd_cycle", 64'(first_rd - cyc_start), 64'd1);
    chk("t1_first_valid_cycle", 64'(first_v - cyc_start), 64'd5);
    chk("t1_done_cycle", 64'(done_cyc - cyc_start), 64'd9);
    chk("t1_addr0", 64'(seen_addr[0]), 64'h010);
    chk("t1_addr3", 64'(seen_addr[3]), 64'h013);
    chk("t1_heads", 64'(heads), 64'd4);
    cmd(10'h3FE, 4, 2);
    wait_done(200);
    chk("t2_addr0", 64'(seen_addr[0]), 64'h3FE);
    chk("t2_addr2", 64'(seen_addr[2]), 64'h000);
    chk("t2_addr7", 64'(seen_addr[7]), 64'h001);
    chk("t2_heads", 64'(heads), 64'd8);
    rdy_pct = 0;
    step();
    cmd(10'h100, 32, 1);
    repeat (50) step();
    chk("t3_reads_before_stall", 64'(rd_seen), 64'(DEPTH));
    chk("t3_valid_while_stalled", 64'(m_tvalid), 64'd1);
    rdy_pct = 100;
    wait_done(500);
    chk("t3_heads", 64'(heads), 64'd32);
    cmd(10'h055, 0, 5);
    wait_done(10);
    chk("t4a_done_cycle", 64'(done_cyc - cyc_start), 64'd1);
    cmd(10'h055, 3, 0);
    wait_done(10);
    chk("t4b_done_cycle", 64'(done_cyc - cyc_start), 64'd1);
    chk("t4b_no_reads", 64'(rd_seen), 64'd0);
    cmd(10'h040, 4, 1);
    step();
    cmd(10'h080, 5, 1);
    wait_done(100);
    chk("t4c_heads", 64'(heads), 64'd4);
    chk("t4c_reads", 64'(rd_seen), 64'd4);
    cmd(10'h200, 16, 1);
    for (int i = 0; i < 20 && rd_seen == 0; i++) step();
    chk("t5_read_started", 64'(rd_seen > 0), 64'd1);
    repeat (2) step();
    rst = 1;
    step();
    rst = 0;
    cmd(10'h300, 3, 1);
    repeat (8) step();
    chk("t5_start_while_flushing", 64'(busy), 64'd0);
    cmd(10'h020, 2, 1);
    wait_done(100);
    chk("t5_heads", 64'(heads), 64'd2);
    chk("t5_addr0", 64'(seen_addr[0]), 64'h020);
    rdy_pct = 50;
    cmd(10'($urandom), 7, 3);
    wait_done(1000);
    chk("t6_heads", 64'(heads), 64'd21);
    for (int t = 0; t < 8; t++) begin
      int nh, nr;
      nh = $urandom_range(1, 12);
      nr = $urandom_range(1, 3);
      rdy_pct = $urandom_range(20, 100);
      cmd(10'($urandom), nh, nr);
      wait_done(2000);
      chk("rand_heads", 64'(heads), 64'(nh * nr));
    end
    chk("reads_left", 64'(exp_rd.size()), 64'd0);
    chk("heads_left", 64'(exp_hd.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/xphm_rd_ctrl.md
Name: xphm_rd_ctrl

Overview:
- Read controller directly downstream of the X packet heads memory (XPHM).
- On a start pulse it sweeps a contiguous range of packet-head addresses, optionally repeated several times. It drives the XPHM read port and collects the returned heads into a small output FIFO.
- Heads are presented on a valid/ready stream to the convolution datapath.
- Credit-based issue control keeps the fixed-latency memory pipeline from overflowing the FIFO under backpressure.

Parameters:
- DATA_WIDTH, 64, packet-head width; equals XPHM_DATA_WIDTH.
- ADDR_WIDTH, 10, XPHM address width; equals clog2(XPHM_DEPTH).
- RD_LATENCY, 3, cycles from xphm_rd_en to xphm_dout_vld; equals XPHM_NUM_PIPE+1.
- FIFO_DEPTH, 8, output FIFO entries; power of two, at least RD_LATENCY+2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_pulse  in  1  one-cycle command start
- base_addr  in  ADDR_WIDTH  first head address
- n_heads  in  16  heads per sweep
- n_rep  in  16  number of sweeps
- busy  out  1  command in progress
- done_pulse  out  1  one-cycle completion
- xphm_rd_en  out  1  XPHM read enable
- xphm_rd_last  out  1  last read of a sweep
- xphm_rd_addr  out  ADDR_WIDTH  XPHM read address
- xphm_dout  in  DATA_WIDTH  XPHM read data
- xphm_dout_vld  in  1  XPHM read data valid
- xphm_dout_last  in  1  XPHM sweep-last tag, delayed with data
- m_tdata  out  DATA_WIDTH  head to consumer
- m_tvalid  out  1  stream valid
- m_tready  in  1  stream ready
- m_tlast_rep  out  1  last head of a sweep
- m_tlast  out  1  last head of the last sweep

Behaviour:
- Reset values: busy, done_pulse, xphm_rd_en, xphm_rd_last, m_tvalid, m_tlast_rep, m_tlast = 0; xphm_rd_addr = 0; FIFO empty; state IDLE.
- Command capture: start_pulse is sampled only in IDLE. base_addr, n_heads and n_rep are latched in that cycle. start_pulse while busy is ignored.
- Degenerate command: n_heads==0 or n_rep==0 issues no reads. done_pulse is asserted the next cycle and busy never rises.
- FSM states:
  - IDLE: on a valid start, go to ISSUE and set busy=1.
  - ISSUE: at most one read per cycle. After the final read of the final sweep, go to DRAIN.
  - DRAIN: wait until in-flight reads = 0, FIFO empty and the last stream handshake is done. Then assert done_pulse for one cycle, clear busy and return to IDLE.
- Issue rule: read only when inflight + fifo_count < FIFO_DEPTH.
  - inflight increments on xphm_rd_en and decrements on xphm_dout_vld; when both occur in the same cycle it is unchanged.
  - The FIFO can never overflow. If xphm_dout_vld arrives with the FIFO full, this is a design error and must be flagged by a simulation assertion.
- Address generation: xphm_rd_addr = (base_addr + head_idx) mod 2^ADDR_WIDTH; wrap-around is legal. head_idx runs 0..n_heads-1 and resets to 0 at each new sweep. rep_idx runs 0..n_rep-1.
- xphm_rd_last = 1 on the head_idx==n_heads-1 read of every sweep. Both xphm_rd_en and xphm_rd_last are registered outputs.
- Latency with no backpressure:
  - start at cycle 0; first xphm_rd_en at cycle 1.
  - xphm_dout_vld at cycle 1+RD_LATENCY; data written to the FIFO that cycle.
  - m_tvalid at cycle 2+RD_LATENCY.
  - Sustained throughput is one head per cycle.
- FIFO entry content: {xphm_dout, xphm_dout_last, final}, where final = (dout_last && this is the final sweep's returning data). The final flag is tracked by a returned-sweep counter incremented on each xphm_dout_vld with xphm_dout_last.
- Stream: m_tdata, m_tlast_rep and m_tlast hold stable while m_tvalid=1 and m_tready=0. An entry is popped on m_tvalid && m_tready. A simultaneous push and pop keeps fifo_count unchanged.
- done_pulse fires one cycle after the handshake carrying m_tlast=1.
- Reset mid-operation: state returns to IDLE and the FIFO is cleared.
  - Reads already in the XPHM pipeline still return. A flush counter loaded with RD_LATENCY on rst discards any xphm_dout_vld while it is nonzero.
  - start_pulse is ignored while flushing.

Test Plan:
- base=0x010, n_heads=4, n_rep=1, m_tready=1 -> reads at addresses 0x010..0x013 on cycles 1..4; xphm_rd_last on 0x013; m_tvalid on cycles 5..8 (RD_LATENCY=3); m_tlast=m_tlast_rep=1 on the 4th head; done_pulse at cycle 9.
- base=0x3FE, n_heads=4, n_rep=2 -> address sequence 0x3FE,0x3FF,0x000,0x001 issued twice; m_tlast_rep on heads 4 and 8; m_tlast only on head 8.
- n_heads=32, n_rep=1, m_tready held 0 for 50 cycles then 1 -> exactly FIFO_DEPTH reads issued before the stall; no overflow assertion; all 32 heads delivered in order and stable while stalled.
- n_heads=0, or n_rep=0 -> no xphm_rd_en; done_pulse the cycle after start; busy stays 0; second start_pulse while busy on a normal command ignored.
- rst asserted 2 cycles after the first read of n_heads=16 -> all outputs at reset values next cycle; returning xphm_dout_vld beats discarded; a new command (base=0x020, n_heads=2, n_rep=1) then completes correctly with exactly 2 heads.
- Random m_tready (50%), n_heads=7, n_rep=3 -> 21 heads matching the scoreboard order; in-flight reads plus FIFO count never exceed FIFO_DEPTH.
